// File: rtl/spi_cmd_rx_if.sv
// Byte stream between the SPI command receiver and the control unit.
// The receiver presents a show-ahead head byte; the control unit pops with next.
interface spi_cmd_rx_if;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       next;

    modport master (
        output out_byte,
        output out_valid,
        input  next
    );

    modport slave (
        input  out_byte,
        input  out_valid,
        output next
    );
endinterface

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that deserialises command bytes into a show-ahead FIFO
// and returns a status byte {overflow, 2'b00, count} on MISO at frame start.
module spi_cmd_rx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sck,
    input  logic                          spi_mosi,
    input  logic                          spi_cs_n,
    output logic                          spi_miso,
    spi_cmd_rx_if.master                  byte_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          rx_active
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    // CS synchroniser resets to "asserted" so a frame already in progress at
    // reset release never looks like a fresh falling edge.
    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_dly, cs_dly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_dly   <= 1'b0;
            cs_dly    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_dly   <= sck_sync[SYNC_STAGES-1];
            cs_dly    <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly;
    assign sck_fall = ~sck_s & sck_dly;
    assign cs_fall  = ~cs_s & cs_dly;
    assign cs_rise  = cs_s & ~cs_dly;

    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      rx_sr_q;
    logic [7:0]      miso_sr_q;
    logic            ovf_q;

    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q;
    logic [7:0]      out_byte_q, head_d;
    logic [7:0]      mem [FIFO_DEPTH];

    logic [7:0]      rx_next;
    logic            frame_start, push_req, pop, full, push_ok, drop;
    logic [4:0]      count_sat;

    assign rx_next     = {rx_sr_q[6:0], mosi_s};
    assign frame_start = (state_q == StIdle) && cs_fall;
    assign push_req    = (state_q == StRecv) && !cs_rise && sck_rise && (bit_cnt_q == 3'd7);
    assign pop         = byte_if.next & out_valid_q;
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign count_sat   = (32'(count_q) > 32'd31) ? 5'd31 : 5'(count_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 8'd0;
            miso_sr_q <= 8'd0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q   <= StRecv;
                        bit_cnt_q <= 3'd0;
                        miso_sr_q <= {ovf_q, 2'b00, count_sat};
                    end
                end
                StRecv: begin
                    // Raising CS mid-byte simply abandons the partial bits.
                    if (cs_rise) begin
                        state_q <= StIdle;
                    end else begin
                        if (sck_rise) begin
                            rx_sr_q   <= rx_next;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (sck_fall) begin
                            miso_sr_q <= {miso_sr_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (frame_start) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop)     rd_d = rd_q + AW'(1);
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        // Next head may be the byte being written this very cycle.
        head_d = out_byte_q;
        if (count_d != '0) begin
            head_d = (push_ok && (rd_d == wr_q)) ? rx_next : mem[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= rx_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'd0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            out_byte_q  <= head_d;
        end
    end

    assign byte_if.out_byte  = out_byte_q;
    assign byte_if.out_valid = out_valid_q;
    assign fifo_count        = count_q;
    assign overflow          = ovf_q;
    assign rx_active         = (state_q == StRecv);
    assign spi_miso          = (state_q == StRecv) & miso_sr_q[7];

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: a bit-banged SPI host feeds frames while a
// queue model of the FIFO predicts popped bytes, occupancy and status bytes.
module tb_spi_cmd_rx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HALF  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       rx_active;

    spi_cmd_rx_if byte_if ();

    spi_cmd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .byte_if    (byte_if),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .rx_active  (rx_active)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q[$];
    bit         model_ovf = 1'b0;
    logic [7:0] exp_status;
    logic [7:0] last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        exp_status = {model_ovf, 2'b00, 5'(exp_q.size())};
        model_ovf  = 1'b0;
        spi_cs_n   = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    // pop_last pulses next in the exact cycle the 8th bit is pushed.
    task automatic send_bits(input logic [7:0] tx, input int nbits, input bit pop_last,
                             output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            if (pop_last && i == 7) begin
                wait_clk(SYNC);
                byte_if.next = 1'b1;
                wait_clk(1);
                byte_if.next = 1'b0;
                wait_clk(HALF - SYNC - 1);
            end else begin
                wait_clk(HALF);
            end
            spi_sck = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] tx, input bit chk_status, input bit pop_last);
        logic [7:0] rx;
        send_bits(tx, 8, pop_last, rx);
        if (chk_status) check("miso_status", rx, exp_status);
        if (pop_last) begin
            last_pop = exp_q.pop_front();
            exp_q.push_back(tx);
        end else if (exp_q.size() < int'(DEPTH)) begin
            exp_q.push_back(tx);
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_valid"}, byte_if.out_valid, 1'b1);
        last_pop = exp_q.pop_front();
        check({tag, "_byte"}, byte_if.out_byte, last_pop);
        byte_if.next = 1'b1;
        wait_clk(1);
        byte_if.next = 1'b0;
        check({tag, "_count"}, fifo_count, exp_q.size());
        wait_clk(1);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
        check({tag, "_empty"}, byte_if.out_valid, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        reset        = 1'b0;
        spi_sck      = 1'b0;
        spi_mosi     = 1'b0;
        spi_cs_n     = 1'b1;
        byte_if.next = 1'b0;
        wait_clk(3);
        check("rst_out_byte", byte_if.out_byte, 8'h00);
        check("rst_out_valid", byte_if.out_valid, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rx_active", rx_active, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        reset = 1'b1;
        wait_clk(HALF);

        // Single byte
        cs_low();
        check("single_rx_active", rx_active, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b0);
        cs_high();
        check("single_valid", byte_if.out_valid, 1'b1);
        check("single_byte", byte_if.out_byte, 8'hA5);
        check("single_count", fifo_count, 5'd1);
        pop_one("single_pop");
        check("single_hold", byte_if.out_byte, 8'hA5);

        // next while empty must not move the pointers
        byte_if.next = 1'b1;
        wait_clk(1);
        byte_if.next = 1'b0;
        wait_clk(1);
        check("empty_next_count", fifo_count, 5'd0);
        check("empty_next_valid", byte_if.out_valid, 1'b0);

        // Burst
        cs_low();
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h7F, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        cs_high();
        check("burst_count", fifo_count, 5'd6);
        drain("burst");

        // Overflow: 17 bytes into 16 entries
        cs_low();
        for (int i = 0; i <= 16; i++) send_byte(8'(i), i == 0, 1'b0);
        cs_high();
        check("ovf_count", fifo_count, 5'd16);
        check("ovf_flag", overflow, 1'b1);

        // Next frame: status 0x90, flag clears, push with coincident pop accepted
        cs_low();
        check("ovf_cleared", overflow, 1'b0);
        check("full_head", byte_if.out_byte, 8'h00);
        send_byte(8'h55, 1'b1, 1'b1);
        check("pushpop_popped", last_pop, 8'h00);
        check("pushpop_count", fifo_count, 5'd16);
        check("pushpop_overflow", overflow, 1'b0);
        cs_high();
        drain("ovf_drain");

        // Abort after 5 bits
        cs_low();
        send_bits(8'hFF, 5, 1'b0, rx);
        cs_high();
        check("abort_count", fifo_count, 5'd0);
        check("abort_valid", byte_if.out_valid, 1'b0);
        cs_low();
        send_byte(8'h3C, 1'b1, 1'b0);
        cs_high();
        drain("abort_next");

        // Async reset mid-byte with three bytes queued
        cs_low();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        check("prereset_count", fifo_count, 5'd3);
        send_bits(8'hF0, 4, 1'b0, rx);
        spi_sck = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("arst_out_byte", byte_if.out_byte, 8'h00);
        check("arst_valid", byte_if.out_valid, 1'b0);
        check("arst_count", fifo_count, 5'd0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_rx_active", rx_active, 1'b0);
        check("arst_miso", spi_miso, 1'b0);
        exp_q.delete();
        model_ovf = 1'b0;
        spi_sck = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(HALF);
        check("no_resume", rx_active, 1'b0);
        cs_high();
        cs_low();
        send_byte(8'h81, 1'b1, 1'b0);
        cs_high();
        check("post_rst_byte", byte_if.out_byte, 8'h81);
        check("post_rst_count", fifo_count, 5'd1);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
